// File: rtl/lfsr_prog.sv
// rtl/lfsr_prog.sv - programmable-width maximal-length Fibonacci LFSR
// Supports seed load, clock enable, step counting, period tick, single-shot stop and zero-seed lockup protection.
module lfsr_prog #(
    parameter int WIDTH = 12,
    parameter int TAPS  = 0,
    parameter int SEED  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             single,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             max_tick,
    output logic [WIDTH-1:0] step_cnt,
    output logic             done,
    output logic             seed_err
);

    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $error("lfsr_prog: WIDTH must be in 4..16");
    end

    if (SEED == 0) begin : g_bad_seed
        $error("lfsr_prog: SEED must be nonzero");
    end

    // Bit t-1 set for every 1-based tap position t.
    function automatic logic [15:0] table_mask(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    localparam logic [31:0]      TAPS_VEC  = TAPS;
    localparam logic [31:0]      SEED_32   = SEED;
    localparam logic [15:0]      FULL_MASK = (TAPS != 0) ? TAPS_VEC[15:0] : table_mask(WIDTH);
    localparam logic [WIDTH-1:0] MASK      = FULL_MASK[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_VEC  = SEED_32[WIDTH-1:0];

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] start;
    logic             feedback;
    logic [WIDTH-1:0] next_state;

    assign feedback   = ^(state & MASK);
    assign next_state = {state[WIDTH-2:0], feedback};
    assign lfsr_out   = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= SEED_VEC;
            start    <= SEED_VEC;
            step_cnt <= '0;
            max_tick <= 1'b0;
            done     <= 1'b0;
            seed_err <= 1'b0;
        end else if (load) begin
            // A zero seed would lock the register, so fall back to SEED and flag it.
            if (seed_in != '0) begin
                state <= seed_in;
                start <= seed_in;
            end else begin
                state    <= SEED_VEC;
                start    <= SEED_VEC;
                seed_err <= 1'b1;
            end
            step_cnt <= '0;
            max_tick <= 1'b0;
            done     <= 1'b0;
        end else if (en && !done) begin
            state <= next_state;
            if (next_state == start) begin
                max_tick <= 1'b1;
                step_cnt <= '0;
                if (single) begin
                    done <= 1'b1;
                end
            end else begin
                max_tick <= 1'b0;
                step_cnt <= step_cnt + WIDTH'(1);
            end
        end else begin
            max_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_prog.sv
// tb/tb_lfsr_prog.sv - directed self-checking bench for lfsr_prog
// Three instances (WIDTH 4, 8, 12) share control inputs; each step checks only the relevant instance.
module tb_lfsr_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, load, single;
    logic [3:0]  seed4;
    logic [7:0]  seed8;
    logic [11:0] seed12;

    logic [3:0]  out4, cnt4;
    logic [7:0]  out8, cnt8;
    logic [11:0] out12, cnt12;
    logic        tick4, done4, err4;
    logic        tick8, done8, err8;
    logic        tick12, done12, err12;

    int checks = 0;
    int errors = 0;

    lfsr_prog #(.WIDTH(4)) u_w4 (
        .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed4), .single(single),
        .lfsr_out(out4), .max_tick(tick4), .step_cnt(cnt4), .done(done4), .seed_err(err4)
    );

    lfsr_prog #(.WIDTH(8)) u_w8 (
        .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed8), .single(single),
        .lfsr_out(out8), .max_tick(tick8), .step_cnt(cnt8), .done(done8), .seed_err(err8)
    );

    lfsr_prog #(.WIDTH(12)) u_w12 (
        .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed12), .single(single),
        .lfsr_out(out12), .max_tick(tick12), .step_cnt(cnt12), .done(done12), .seed_err(err12)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // Hand-derived WIDTH=4 sequence from seed 0001 with taps (4,3).
    logic [3:0] seq4 [0:14];
    bit         seen [0:4095];

    initial begin
        int tick_bad, dup, zero, first_tick, second_tick, cnt_max;
        seq4 = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
        reset = 1'b0; en = 1'b0; load = 1'b0; single = 1'b0;
        seed4 = 4'h0; seed8 = 8'h00; seed12 = 12'h000;
        @(negedge clk);
        tick();
        tick();

        check("rst_out4", out4, 4'h1);
        check("rst_out12", out12, 12'h001);
        check("rst_cnt4", cnt4, 4'h0);
        check("rst_flags4", {tick4, done4, err4}, 3'b000);
        check("rst_flags8", {tick8, done8, err8}, 3'b000);
        reset = 1'b1;

        // Test 1: WIDTH=4 full period.
        en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("t1_state_%0d", i + 1), out4, seq4[i]);
            if (i < 14) begin
                check($sformatf("t1_cnt_%0d", i + 1), cnt4, 32'(i + 1));
                check($sformatf("t1_tick_%0d", i + 1), tick4, 1'b0);
            end
        end
        check("t1_wrap_tick", tick4, 1'b1);
        check("t1_wrap_cnt", cnt4, 4'h0);
        tick();
        check("t1_tick_clear", tick4, 1'b0);
        check("t1_after_wrap", out4, 4'h2);

        // Test 2: WIDTH=12 two periods.
        en = 1'b0;
        do_reset();
        en = 1'b1;
        tick_bad = 0; dup = 0; zero = 0; first_tick = 0; second_tick = 0; cnt_max = 0;
        for (int k = 1; k <= 8190; k++) begin
            tick();
            if (tick12 === 1'b1) begin
                if (first_tick == 0) first_tick = k;
                else if (second_tick == 0) second_tick = k;
                else tick_bad++;
            end
            if (k <= 4095) begin
                if (out12 == 12'h000) zero++;
                if (seen[out12]) dup++;
                seen[out12] = 1'b1;
            end
            if (k == 4094) cnt_max = int'(cnt12);
        end
        check("t2_first_tick", first_tick, 4095);
        check("t2_second_tick", second_tick, 8190);
        check("t2_extra_ticks", tick_bad, 0);
        check("t2_duplicates", dup, 0);
        check("t2_zero_state", zero, 0);
        check("t2_cnt_max", cnt_max, 4094);
        check("t2_final_state", out12, 12'h001);

        // Test 3: WIDTH=8 zero-seed protection.
        en = 1'b0;
        do_reset();
        load = 1'b1; seed8 = 8'h00; seed4 = 4'h5; seed12 = 12'h123;
        tick();
        check("t3_zero_out", out8, 8'h01);
        check("t3_zero_err", err8, 1'b1);
        seed8 = 8'h5A;
        tick();
        check("t3_reload_out", out8, 8'h5A);
        check("t3_err_sticky", err8, 1'b1);
        tick();
        check("t3_err_sticky2", err8, 1'b1);
        load = 1'b0;
        do_reset();
        check("t3_rst_clears", err8, 1'b0);
        check("t3_rst_out", out8, 8'h01);

        // Test 4: WIDTH=8 single-shot.
        single = 1'b1; load = 1'b1; seed8 = 8'h5A;
        tick();
        load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 255; k++) begin
            tick();
            if (k == 254) check("t4_not_done_254", done8, 1'b0);
        end
        check("t4_done", done8, 1'b1);
        check("t4_out", out8, 8'h5A);
        check("t4_tick", tick8, 1'b1);
        check("t4_cnt", cnt8, 8'h00);
        single = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check("t4_frozen_out", out8, 8'h5A);
        check("t4_frozen_cnt", cnt8, 8'h00);
        check("t4_still_done", done8, 1'b1);
        check("t4_tick_low", tick8, 1'b0);
        load = 1'b1; seed8 = 8'h33;
        tick();
        check("t4_reload_done", done8, 1'b0);
        check("t4_reload_out", out8, 8'h33);
        load = 1'b0;
        tick();
        check("t4_resume_out", out8, 8'h66);
        check("t4_resume_cnt", cnt8, 8'h01);

        // Test 5: WIDTH=4 with en toggling.
        en = 1'b0;
        do_reset();
        for (int c = 1; c <= 30; c++) begin
            en = (c % 2 == 1);
            tick();
            if (c == 2) check("t5_c2_state", out4, 4'h2);
            if (c == 28) check("t5_c28_state", {out4, cnt4}, {4'h8, 4'hE});
            if (c == 29) check("t5_c29_tick", {out4, tick4}, {4'h1, 1'b1});
        end
        check("t5_c30", {out4, cnt4, tick4}, {4'h1, 4'h0, 1'b0});

        // Test 6: load beats en, then reset mid-run.
        en = 1'b0; load = 1'b1; seed4 = 4'h0;
        tick();
        check("t6_pre_err", err4, 1'b1);
        en = 1'b1; seed4 = 4'h6;
        tick();
        check("t6_load_wins", {out4, cnt4}, {4'h6, 4'h0});
        load = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("t6_step4", {out4, cnt4}, {4'hB, 4'h4});
        reset = 1'b0; load = 1'b1; seed4 = 4'h3;
        tick();
        check("t6_rst_state", {out4, cnt4}, {4'h1, 4'h0});
        check("t6_rst_flags", {tick4, done4, err4}, 3'b000);
        reset = 1'b1; load = 1'b0; en = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
